// File: rtl/dmem_hs_pkg.sv
// Shared types and decode helpers for the dmem_hs data memory.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_t;

  // Load-side legality plus alignment; stores additionally reject func3[2].
  function automatic logic lane_ok(input logic [2:0] func3, input logic [1:0] lane);
    case (func3)
      F3_B, F3_BU: return 1'b1;
      F3_H, F3_HU: return ~lane[0];
      F3_W:        return (lane == 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_hs_if.sv
// Request/response handshake bundle between the MEM stage and dmem_hs.
interface dmem_hs_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;

  modport master (
    output req_valid, req_we, req_func3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_func3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/dmem_hs_array.sv
// Word-organised storage with byte-lane write enables and a registered read port.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  input  logic             re_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_hs.sv
// MEM-stage data memory: handshake FSM, wait counter, access decode and load extension.
module dmem_hs
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  dmem_hs_if.slave    bus
);

  localparam int unsigned AW        = $clog2(DEPTH_BYTES);
  localparam int unsigned IDX_W     = (AW > 2) ? AW - 2 : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  dmem_state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic [ADDR_W-1:0] addr_in;
  logic [1:0]        lane;
  logic [IDX_W-1:0]  idx;
  logic              fault_c;
  logic              perform;
  logic [3:0]        be;
  logic [31:0]       wr_word;
  logic [31:0]       arr_rdata;
  logic [31:0]       shifted;
  logic [31:0]       ext;

  assign addr_in = bus.req_addr;

  generate
    if (ADDR_W > AW) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^addr_in[ADDR_W-1:AW];
    end
    if (AW > 2) begin : g_idx
      assign idx = addr_q[AW-1:2];
    end else begin : g_idx_single
      assign idx = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = BUSY;
          cnt_d   = WAIT_INIT;
          we_d    = bus.req_we;
          f3_d    = bus.req_func3;
          addr_d  = addr_in[AW-1:0];
          wdata_d = bus.req_wdata;
        end
      end
      BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
        else             state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode works on the captured request so late req_* changes cannot leak in.
  always_comb begin
    lane    = addr_q[1:0];
    fault_c = ~lane_ok(f3_q, lane) | (we_q & f3_q[2]);
    perform = (state_q == BUSY) && (cnt_q == '0);
    case (f3_q[1:0])
      2'b00: begin
        be      = 4'b0001 << lane;
        wr_word = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be      = 4'b0011 << lane;
        wr_word = {2{wdata_q[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        wr_word = wdata_q;
      end
    endcase
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_BYTES / 4),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk    (clk),
    .we_i   (perform & we_q & ~fault_c & ~rst),
    .be_i   (be),
    .idx_i  (idx),
    .wdata_i(wr_word),
    .re_i   (perform & ~we_q),
    .rdata_o(arr_rdata)
  );

  always_comb begin
    shifted = arr_rdata >> {lane, 3'b000};
    case (f3_q)
      F3_B:    ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ext = {24'h0, shifted[7:0]};
      F3_H:    ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ext = {16'h0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  // The array read register is only loaded at the perform edge, so RESP output is stable.
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_fault = (state_q == RESP) & fault_c;
    bus.rsp_rdata = ((state_q == RESP) && !we_q && !fault_c) ? ext : '0;
  end

endmodule
